// File: rtl/gmii_egress_tx.sv
// ---------------------------------------------------------------------------
// gmii_egress_tx
//   Egress side of a GMII switch port. Routed ingress bytes whose port mask
//   selects this port are buffered whole-frame in a byte FIFO. A frame is
//   committed only once its last byte is stored, so the transmitter never
//   starts a frame it cannot finish. Frames that do not fit are dropped and
//   counted. Committed frames are replayed on GMII with an inter-frame gap.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   in_data        routed ingress byte
//   in_dv          routed ingress data valid (one frame = one high run)
//   in_err         routed ingress byte error
//   in_port_index  destination port mask, sampled on the first byte only
//   gmii_tx_data   GMII transmit byte
//   gmii_tx_en     GMII transmit enable
//   gmii_tx_er     GMII transmit error
//   frames_pending committed frames whose transmission has not started
//   drop_count     frames dropped on overflow, saturating at 0xFFFF
// ---------------------------------------------------------------------------
module gmii_egress_tx #(
   parameter int PORT_ID     = 0,
   parameter int PORT_NUMBER = 4,
   parameter int FIFO_DEPTH  = 2048,
   parameter int IFG_CYCLES  = 12
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [7:0]                   in_data,
   input  logic                         in_dv,
   input  logic                         in_err,
   input  logic [PORT_NUMBER-1:0]       in_port_index,
   output logic [7:0]                   gmii_tx_data,
   output logic                         gmii_tx_en,
   output logic                         gmii_tx_er,
   output logic [$clog2(FIFO_DEPTH):0]  frames_pending,
   output logic [15:0]                  drop_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int IW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
   localparam logic [IW-1:0] IFG_LAST = IW'(IFG_CYCLES - 1);

   typedef struct packed {
      logic [7:0] data;
      logic       err;
      logic       last;
   } entry_t;

   typedef enum logic [1:0] {IDLE, READ, TX, IFG} state_t;

   // ---------------- write side ----------------
   logic          in_dv_q;      // previous in_dv, for frame-start detection
   logic          accepting;    // current frame is for this port and still alive
   logic          pend_valid;   // one-byte holding stage: last is known a cycle late
   logic [7:0]    pend_data;
   logic          pend_err;
   logic [AW:0]   wr_ptr;       // speculative write pointer
   logic [AW:0]   cm_ptr;       // commit pointer, rewind target on overflow
   logic [AW:0]   rd_ptr;

   logic          port_hit;
   logic          frame_start;
   logic          take;
   logic          wr_last;
   logic          fifo_full;
   logic          overflow;
   logic          wr_en;
   logic          commit;
   entry_t        wr_entry;

   // ---------------- read side ----------------
   state_t        state;
   state_t        state_nx;
   logic [IW-1:0] ifg_cnt;
   logic          rd_en;
   logic          start;
   entry_t        rd_entry;

   entry_t        mem [FIFO_DEPTH];

   assign port_hit = |(in_port_index & (PORT_NUMBER'(1) << PORT_ID));

   // NOTE: every combinational output gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      frame_start = in_dv && !in_dv_q;
      take        = in_dv && (frame_start ? port_hit : accepting);
      // The held byte is the frame's last one exactly when in_dv has dropped.
      wr_last     = pend_valid && !in_dv;
      fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      overflow    = pend_valid && fifo_full;
      wr_en       = pend_valid && !fifo_full;
      commit      = wr_en && wr_last;
      wr_entry    = '{data: pend_data, err: pend_err, last: wr_last};
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_dv_q    <= 1'b1;   // a frame already running at release is not a frame start
         accepting  <= 1'b0;
         pend_valid <= 1'b0;
         pend_data  <= '0;
         pend_err   <= 1'b0;
         wr_ptr     <= '0;
         cm_ptr     <= '0;
         drop_count <= '0;
      end else begin
         in_dv_q <= in_dv;
         if (frame_start) begin
            accepting <= port_hit;
         end
         if (overflow) begin
            // Abandon the frame: forget what was written and ignore the rest.
            accepting  <= 1'b0;
            pend_valid <= 1'b0;
            wr_ptr     <= cm_ptr;
            if (drop_count != 16'hFFFF) begin
               drop_count <= drop_count + 1'b1;
            end
         end else begin
            pend_valid <= take;
            if (take) begin
               pend_data <= in_data;
               pend_err  <= in_err;
            end
            if (wr_en) begin
               wr_ptr <= wr_ptr + 1'b1;
               if (wr_last) begin
                  cm_ptr <= wr_ptr + 1'b1;
               end
            end
         end
      end
   end

   // NOTE: the frame buffer has no reset; pointers define which entries are
   // live, and clearing a RAM would prevent block-RAM mapping.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= wr_entry;
      end
      if (rd_en) begin
         rd_entry <= mem[rd_ptr[AW-1:0]];
      end
   end

   // ---------------- TX state machine ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         rd_ptr         <= '0;
         ifg_cnt        <= '0;
         frames_pending <= '0;
      end else begin
         state <= state_nx;
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (state == TX) begin
            ifg_cnt <= IFG_LAST;
         end else if (state == IFG) begin
            ifg_cnt <= ifg_cnt - 1'b1;
         end
         case ({commit, start})
            2'b10:   frames_pending <= frames_pending + 1'b1;
            2'b01:   frames_pending <= frames_pending - 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (frames_pending != '0) state_nx = READ;
         READ: state_nx = TX;
         TX:   if (rd_entry.last) state_nx = IFG;
         IFG:  if (ifg_cnt == '0) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      start        = (state == IDLE) && (frames_pending != '0);
      // Prefetch the next entry while driving the current one so bytes flow
      // without gaps; stop once the last entry is on the wire.
      rd_en        = (state == READ) || ((state == TX) && !rd_entry.last);
      gmii_tx_en   = (state == TX);
      gmii_tx_data = (state == TX) ? rd_entry.data : 8'h00;
      gmii_tx_er   = (state == TX) ? rd_entry.err  : 1'b0;
   end

endmodule

// File: tb/tb_gmii_egress_tx.sv
// ---------------------------------------------------------------------------
// tb_gmii_egress_tx
//   Directed bench for gmii_egress_tx (PORT_ID=0, 4 ports, 64-byte FIFO).
//   The model is a queue of expected output bytes filled as frames are sent
//   (frames not addressed to this port, or known to overflow, add nothing).
//   A negedge monitor compares every transmitted byte against the queue,
//   checks the idle bus is all zeros, and records burst timing for the
//   latency and inter-frame-gap checks.
// ---------------------------------------------------------------------------
module tb_gmii_egress_tx;

   localparam int PORT_ID     = 0;
   localparam int PORT_NUMBER = 4;
   localparam int FIFO_DEPTH  = 64;
   localparam int IFG_CYCLES  = 12;

   logic                        clk = 1'b0;
   logic                        rst_n = 1'b0;
   logic [7:0]                  in_data = '0;
   logic                        in_dv = 1'b0;
   logic                        in_err = 1'b0;
   logic [PORT_NUMBER-1:0]      in_port_index = '0;
   logic [7:0]                  gmii_tx_data;
   logic                        gmii_tx_en;
   logic                        gmii_tx_er;
   logic [$clog2(FIFO_DEPTH):0] frames_pending;
   logic [15:0]                 drop_count;

   gmii_egress_tx #(
      .PORT_ID     (PORT_ID),
      .PORT_NUMBER (PORT_NUMBER),
      .FIFO_DEPTH  (FIFO_DEPTH),
      .IFG_CYCLES  (IFG_CYCLES)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_data        (in_data),
      .in_dv          (in_dv),
      .in_err         (in_err),
      .in_port_index  (in_port_index),
      .gmii_tx_data   (gmii_tx_data),
      .gmii_tx_en     (gmii_tx_en),
      .gmii_tx_er     (gmii_tx_er),
      .frames_pending (frames_pending),
      .drop_count     (drop_count)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   always @(posedge clk) cyc++;

   // Expected transmit stream: {data, err, last} per byte.
   logic [9:0] exp_q[$];

   // Monitor observations.
   int  rise_q[$];
   int  fall_q[$];
   bit  in_burst     = 1'b0;
   bit  want_end     = 1'b0;
   int  burst_len    = 0;
   int  first_byte   = -1;
   int  err_pos_seen = 0;
   int  err_count    = 0;
   int  pend_up      = -100;
   int  pend_dn      = -100;
   int  prev_fp      = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] byte_val(input int seed, input int i);
      return 8'((seed * 37 + i * 13 + 5) % 256);
   endfunction

   // ---------------- monitor / compare process ----------------
   always @(negedge clk) begin
      logic [9:0] e;
      if (!rst_n) begin
         check("rst_tx_en", {31'd0, gmii_tx_en}, 0);
         check("rst_tx_data", {24'd0, gmii_tx_data}, 0);
         check("rst_tx_er", {31'd0, gmii_tx_er}, 0);
         check("rst_frames_pending", 32'(frames_pending), 0);
         check("rst_drop_count", {16'd0, drop_count}, 0);
         in_burst = 1'b0;
         want_end = 1'b0;
         prev_fp  = 0;
      end else begin
         if (frames_pending == 1 && prev_fp == 0) pend_up = cyc;
         if (frames_pending == 0 && prev_fp == 1) pend_dn = cyc;
         prev_fp = int'(frames_pending);
         if (gmii_tx_en) begin
            if (in_burst && want_end) check("byte_after_last", 1, 0);
            if (!in_burst) begin
               in_burst     = 1'b1;
               rise_q.push_back(cyc);
               burst_len    = 0;
               err_pos_seen = 0;
               err_count    = 0;
               first_byte   = int'(gmii_tx_data);
            end
            burst_len++;
            if (gmii_tx_er) begin
               err_pos_seen = burst_len;
               err_count++;
            end
            if (exp_q.size() == 0) begin
               check("unexpected_tx_byte", 1, 0);
               want_end = 1'b0;
            end else begin
               e = exp_q.pop_front();
               check("tx_data", {24'd0, gmii_tx_data}, {24'd0, e[9:2]});
               check("tx_er", {31'd0, gmii_tx_er}, {31'd0, e[1]});
               want_end = e[0];
            end
         end else begin
            if (in_burst) begin
               in_burst = 1'b0;
               fall_q.push_back(cyc);
               check("burst_ends_on_last", {31'd0, want_end}, 1);
               want_end = 1'b0;
            end
            check("idle_tx_data", {24'd0, gmii_tx_data}, 0);
            check("idle_tx_er", {31'd0, gmii_tx_er}, 0);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic dv, input logic [7:0] d, input logic er,
                        input logic [PORT_NUMBER-1:0] idx);
      @(posedge clk);
      #1;
      in_dv         = dv;
      in_data       = d;
      in_err        = er;
      in_port_index = idx;
   endtask

   // Drives len bytes then one idle cycle. The mask is only valid on byte 0;
   // later bytes carry its complement so late sampling is visible.
   task automatic send_frame(input int len, input logic [PORT_NUMBER-1:0] mask,
                             input int seed, input int err_byte, input bit expect_drop);
      bit         acc;
      logic [7:0] d;
      logic       er;
      acc = mask[PORT_ID] && !expect_drop;
      for (int i = 0; i < len; i++) begin
         d  = byte_val(seed, i);
         er = (i + 1 == err_byte);
         drive(1'b1, d, er, (i == 0) ? mask : ~mask);
         if (acc) exp_q.push_back({d, er, (i == len - 1)});
      end
      drive(1'b0, 8'h00, 1'b0, '0);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || gmii_tx_en || frames_pending != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drained"}, {31'd0, (n < budget)}, 1);
      repeat (IFG_CYCLES + 4) @(negedge clk);
   endtask

   task automatic clear_marks();
      rise_q.delete();
      fall_q.delete();
      burst_len    = 0;
      first_byte   = -1;
      err_pos_seen = 0;
      err_count    = 0;
      pend_up      = -100;
      pend_dn      = -100;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;

      // Literal pins for the data pattern used below.
      check("pattern_s1_b0", {24'd0, byte_val(1, 0)}, 42);
      check("pattern_s1_b9", {24'd0, byte_val(1, 9)}, 159);

      repeat (4) @(negedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_pending", 32'(frames_pending), 0);
      check("post_rst_drops", {16'd0, drop_count}, 0);

      // 64-byte frame for this port: whole frame out, tx_en 2 edges after commit.
      clear_marks();
      send_frame(64, 4'b0001, 1, 0, 1'b0);
      wait_idle("f64", 400);
      check("f64_bursts", rise_q.size(), 1);
      check("f64_len", burst_len, 64);
      check("f64_first_byte", first_byte, 42);
      check("f64_latency", rise_q.size() > 0 ? rise_q[0] - pend_up : -1, 2);
      check("f64_pending_1_to_0", pend_dn - pend_up, 1);
      check("f64_pending_end", 32'(frames_pending), 0);

      // Frame not addressed to port 0: no activity, no counters.
      clear_marks();
      send_frame(50, 4'b1110, 2, 0, 1'b0);
      wait_idle("masked", 400);
      check("masked_bursts", rise_q.size(), 0);
      check("masked_pending", 32'(frames_pending), 0);
      check("masked_drops", {16'd0, drop_count}, 0);

      // Two 60-byte frames, one idle input cycle apart. The low run between
      // bursts is IFG_CYCLES of IFG plus one IDLE and one READ cycle.
      clear_marks();
      send_frame(60, 4'b0001, 3, 0, 1'b0);
      send_frame(60, 4'b0011, 4, 0, 1'b0);
      wait_idle("b2b", 600);
      check("b2b_bursts", rise_q.size(), 2);
      check("b2b_len", burst_len, 60);
      check("b2b_gap", (rise_q.size() > 1 && fall_q.size() > 0) ? rise_q[1] - fall_q[0] : -1,
            IFG_CYCLES + 2);

      // Error flag on byte 10 only.
      clear_marks();
      send_frame(30, 4'b0001, 5, 10, 1'b0);
      wait_idle("err", 400);
      check("err_position", err_pos_seen, 10);
      check("err_count", err_count, 1);

      // Overflow: 60-byte frame transmitting while a 100-byte frame arrives
      // into the 64-entry buffer; the 100-byte frame is dropped, the next
      // 20-byte frame survives intact.
      clear_marks();
      send_frame(60, 4'b0001, 6, 0, 1'b0);
      send_frame(100, 4'b0001, 7, 0, 1'b1);
      send_frame(20, 4'b0001, 8, 0, 1'b0);
      wait_idle("ovf", 800);
      check("ovf_drops", {16'd0, drop_count}, 1);
      check("ovf_bursts", rise_q.size(), 2);
      check("ovf_last_len", burst_len, 20);
      check("ovf_pending", 32'(frames_pending), 0);

      // Reset mid-TX, released mid-input-frame.
      clear_marks();
      send_frame(40, 4'b0001, 9, 0, 1'b0);
      n = 0;
      while (rise_q.size() == 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rst_test_tx_started", {31'd0, (n < 200)}, 1);
      repeat (10) @(negedge clk);
      @(posedge clk);
      #2;
      check("tx_active_before_reset", {31'd0, gmii_tx_en}, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_tx_en_drop", {31'd0, gmii_tx_en}, 0);
      check("async_tx_data_zero", {24'd0, gmii_tx_data}, 0);
      check("async_pending_zero", 32'(frames_pending), 0);
      exp_q.delete();
      clear_marks();
      for (int i = 0; i < 3; i++) drive(1'b1, byte_val(11, i), 1'b0, 4'b0001);
      #2;
      rst_n = 1'b1;
      for (int i = 3; i < 13; i++) drive(1'b1, byte_val(11, i), 1'b0, 4'b0001);
      drive(1'b0, 8'h00, 1'b0, '0);
      repeat (2) @(negedge clk);
      check("partial_ignored_pending", 32'(frames_pending), 0);
      send_frame(30, 4'b0001, 10, 0, 1'b0);
      wait_idle("after_rst", 400);
      check("after_rst_bursts", rise_q.size(), 1);
      check("after_rst_len", burst_len, 30);
      check("after_rst_first", first_byte, int'(byte_val(10, 0)));
      check("after_rst_drops", {16'd0, drop_count}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
